btn_event_ctrl: RTL
===================

// Module: btn_event_ctrl
// PURPOSE
//  Event controller behind a bank of DeBounce instances. Takes NUM_BTN debounced button
//  levels and detects press, release and long-press. Round-robin arbitration queues the
//  events into a small FIFO, drained by a valid/ready consumer (UI FSM, LED/menu logic).
// PARAMETERS
//  NUM_BTN    4      number of debounced button inputs (2..16)
//  TICK_DIV   50000  clk cycles per hold-timer tick (1 ms at 50 MHz), >=2
//  LONG_TICKS 1000   ticks a button must stay pressed to raise LONG (>=1)
//  FIFO_DEPTH 4      event queue depth, power of 2, >=2
//  IDX_W      $clog2(NUM_BTN)  derived localparam; button index width
// PORTS
//  clk          in   1        system clock
//  n_reset      in   1        asynchronous active-low reset
//  db_in        in   NUM_BTN  debounced levels, 1 = pressed, synchronous to clk
//  evt_valid    out  1        FIFO head holds an event
//  evt_ready    in   1        consumer accepts head when evt_valid && evt_ready
//  evt_btn      out  IDX_W    button index of head event
//  evt_code     out  2        01 PRESS, 10 RELEASE, 11 LONG (00 never output while valid)
//  overflow     out  1        sticky: an event was dropped
//  clr_overflow in   1        synchronous clear of overflow (wins over a same-cycle set)
// BEHAVIOUR
//  - Async reset: FIFO empty, evt_valid/evt_btn/evt_code/overflow = 0, all FSMs IDLE,
//    db_q = 0, tick counter 0, rr_ptr = 0, all pending bits 0. Buttons held at release
//    of reset therefore emit PRESS.
//  - Tick: counter 0..TICK_DIV-1; tick pulses one cycle when the counter wraps. Free-running.
//  - Per-button FSM (db_q = registered db_in):
//    IDLE  : db_in & ~db_q -> set pend_press, hold_cnt=0, go HELD
//    HELD  : tick -> hold_cnt++; tick && hold_cnt==LONG_TICKS-1 -> set pend_long, go LONG
//            ~db_in -> set pend_rel, go IDLE (release beats a same-cycle long)
//    LONG  : ~db_in -> set pend_rel, go IDLE
//  - Pending bits: 3 per button. Setting a bit that is still set drops the new event and
//    sets overflow. Same-cycle set and grant-clear of one bit: the new event stays pending.
//  - Arbitration: one grant per cycle, only when FIFO count < FIFO_DEPTH. Search buttons
//    from rr_ptr upward (wrapping); first button with any pending bit wins. rr_ptr <= winner+1
//    mod NUM_BTN. Within a button the order is PRESS > LONG > RELEASE (chronological).
//    Grant pushes {idx,code} and clears that bit in the same edge.
//  - Latency: a rising db_in sampled at edge k sets pend at k, pushes at k+1,
//    evt_valid=1 after k+1 (2 cycles, uncontended, FIFO not full).
//  - FIFO: evt_* driven from mem[rd_ptr]; head stable while evt_valid && !evt_ready.
//    Push+pop in one cycle leaves the count unchanged. Full blocks the grant only; pending
//    bits hold (no loss) until space frees. Pop on empty is ignored. Pointers wrap mod DEPTH.
//  - Hold counter width is $clog2(LONG_TICKS+1). It saturates in LONG.
// STRUCTURE
//  - Package btn_evt_pkg: EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_LONG=2'b11,
//    FSM state encodings ST_IDLE/ST_HELD/ST_LONG.
//  - Sub-module btn_evt_fifo (sync FIFO, width IDX_W+2, depth FIFO_DEPTH, count output).
//  - Top: tick prescaler, NUM_BTN FSMs (generate loop), pending regs, rr arbiter.
// TESTING (bench params: NUM_BTN=4, TICK_DIV=4, LONG_TICKS=3, FIFO_DEPTH=4)
//  1 ready=1; db_in[2] 0->1, held 5 cycles, ->0 -> (btn2,PRESS) 2 cycles after rise,
//    (btn2,RELEASE) 2 cycles after fall; no LONG; overflow=0.
//  2 ready=1; hold db_in[0] 20 cycles -> PRESS, then LONG exactly once on the 3rd tick
//    after press, then RELEASE after fall; 3 events total.
//  3 ready=1; db_in 4'b0000->4'b1111 in one cycle -> PRESS for btn0,1,2,3 on 4
//    consecutive cycles. Repeat with rr_ptr=2 -> order 2,3,0,1.
//  4 ready=0; generate 6 events -> evt_valid=1, head constant, FIFO holds 4, 2 remain
//    pending, overflow=0. Then ready=1 -> all 6 delivered in order, no loss.
//  5 ready=0, FIFO full; press/release btn1 twice -> overflow=1. clr_overflow pulse -> 0.
//    clr_overflow with a same-cycle drop -> overflow=0.
//  6 n_reset low mid-stream with FIFO non-empty -> evt_valid=0 and overflow=0 immediately
//    (before the next clk edge). After release, a held button yields one PRESS.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared event codes and per-button FSM state encoding for the button event controller.
package btn_evt_pkg;

    localparam int unsigned EVT_CODE_W = 2;

    localparam logic [EVT_CODE_W-1:0] EVT_PRESS   = 2'b01;
    localparam logic [EVT_CODE_W-1:0] EVT_RELEASE = 2'b10;
    localparam logic [EVT_CODE_W-1:0] EVT_LONG    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO with a registered head, valid flag and occupancy count.
module btn_evt_fifo #(
    parameter  int unsigned W     = 4,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & valid;
    assign do_push = push & (count != CNT_W'(DEPTH));
    assign rd_nxt  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign cnt_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head is re-registered from the post-edge state so it bypasses a write into the new head slot.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            valid  <= (cnt_nxt != '0);
            if (do_push && (wr_ptr == rd_nxt)) begin
                dout <= din;
            end else begin
                dout <= mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Press / release / long-press detection for a bank of debounced buttons, round-robin
// arbitrated into a small event FIFO drained by a valid/ready consumer.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter  int unsigned NUM_BTN    = 4,
    parameter  int unsigned TICK_DIV   = 50000,
    parameter  int unsigned LONG_TICKS = 1000,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDX_W      = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_BTN-1:0] db_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_btn,
    output logic [1:0]         evt_code,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DATA_W = IDX_W + EVT_CODE_W;

    logic [TICK_W-1:0]     tick_cnt;
    logic                  tick_c;
    logic [NUM_BTN-1:0]    db_q;
    logic [NUM_BTN-1:0]    set_press, set_long, set_rel;
    logic [NUM_BTN-1:0]    pend_press_q, pend_long_q, pend_rel_q;
    logic [NUM_BTN-1:0]    clr_press, clr_long, clr_rel;
    logic [NUM_BTN-1:0]    any_pend;
    logic [IDX_W-1:0]      rr_ptr;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic [EVT_CODE_W-1:0] gnt_code;
    logic [IDX_W-1:0]      cand;
    logic                  drop_c;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [DATA_W-1:0]     fifo_head;

    // Free-running hold-timer prescaler.
    assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tick_cnt <= '0;
            db_q     <= '0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
            db_q     <= db_in;
        end
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_state_e        state_q, state_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              press_c, long_c, rel_c;

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end

        // A release in HELD is checked before the tick so it beats a same-cycle long.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            press_c = 1'b0;
            long_c  = 1'b0;
            rel_c   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (db_in[gi] && !db_q[gi]) begin
                        press_c = 1'b1;
                        hold_d  = '0;
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!db_in[gi]) begin
                        rel_c   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tick_c) begin
                        hold_d = hold_q + HOLD_W'(1);
                        if (hold_q == HOLD_W'(LONG_TICKS - 1)) begin
                            long_c  = 1'b1;
                            state_d = ST_LONG;
                        end
                    end
                end
                ST_LONG: begin
                    if (!db_in[gi]) begin
                        rel_c   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tick_c && (hold_q != HOLD_W'(LONG_TICKS))) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        assign set_press[gi] = press_c;
        assign set_long[gi]  = long_c;
        assign set_rel[gi]   = rel_c;
    end

    assign any_pend = pend_press_q | pend_long_q | pend_rel_q;

    // Round-robin search from rr_ptr; within a button PRESS > LONG > RELEASE.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_code  = EVT_PRESS;
        cand      = '0;
        clr_press = '0;
        clr_long  = '0;
        clr_rel   = '0;
        if (fifo_cnt < CNT_W'(FIFO_DEPTH)) begin
            for (int k = 0; k < int'(NUM_BTN); k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % int'(NUM_BTN));
                if (!gnt_valid && any_pend[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
        if (gnt_valid) begin
            if (pend_press_q[gnt_idx]) begin
                gnt_code           = EVT_PRESS;
                clr_press[gnt_idx] = 1'b1;
            end else if (pend_long_q[gnt_idx]) begin
                gnt_code          = EVT_LONG;
                clr_long[gnt_idx] = 1'b1;
            end else begin
                gnt_code         = EVT_RELEASE;
                clr_rel[gnt_idx] = 1'b1;
            end
        end
    end

    // A set on a bit still pending (and not being granted this cycle) loses the new event.
    assign drop_c = |((set_press & pend_press_q & ~clr_press) |
                      (set_long  & pend_long_q  & ~clr_long)  |
                      (set_rel   & pend_rel_q   & ~clr_rel));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend_press_q <= '0;
            pend_long_q  <= '0;
            pend_rel_q   <= '0;
            rr_ptr       <= '0;
            overflow     <= 1'b0;
        end else begin
            pend_press_q <= set_press | (pend_press_q & ~clr_press);
            pend_long_q  <= set_long  | (pend_long_q  & ~clr_long);
            pend_rel_q   <= set_rel   | (pend_rel_q   & ~clr_rel);
            if (gnt_valid) begin
                rr_ptr <= (gnt_idx == IDX_W'(NUM_BTN - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
            if (clr_overflow) begin
                overflow <= 1'b0;
            end else if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    btn_evt_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (gnt_valid),
        .din     ({gnt_idx, gnt_code}),
        .pop     (evt_ready),
        .dout    (fifo_head),
        .valid   (evt_valid),
        .count   (fifo_cnt)
    );

    assign evt_btn  = fifo_head[DATA_W-1:EVT_CODE_W];
    assign evt_code = fifo_head[EVT_CODE_W-1:0];

endmodule
